// File: rtl/apb_initiator.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns exactly one response per accepted command.
// One transfer is outstanding at a time. A transfer ends either when the
// completer raises pready, or after TIMEOUT ACCESS cycles without pready
// (TIMEOUT = 0 waits forever). DATA_W is expected to be 8, 16 or 32.
module apb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  // command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  // response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  // APB requester side
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  localparam int STRB_W = DATA_W / 8;
  // Wide enough to hold TIMEOUT; at least one bit so TIMEOUT = 0 still elaborates.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic             TO_EN    = (TIMEOUT != 0);
  // Counter value during the last ACCESS cycle before the timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic              w_accept;
  logic              w_timeout;

  // cmd_ready is registered, so it only rises on the first edge after reset release.
  assign w_accept  = cmd_valid & r_cmd_ready;
  // Timeout fires on the TIMEOUT-th ACCESS cycle that still sees pready low;
  // pready in that same cycle wins and completes normally.
  assign w_timeout = TO_EN && !pready && (r_cnt == CNT_LAST);

  // Transfer sequencer: state, APB control/data and response registers.
  // NOTE: every output is a flop cleared by the async reset, datapath included,
  // so the whole port goes to 0 immediately when rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_state     <= S_SETUP;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_cnt       <= '0;
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_pstrb     <= cmd_write ? cmd_strb : '0;
          end
        end

        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end

        S_ACCESS: begin
          // Saturating wait counter; it never wraps even with the timeout disabled.
          if (!pready && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (pready || w_timeout) begin
            r_state       <= S_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= pready ? pslverr : 1'b1;
            r_rsp_timeout <= !pready;
            r_rsp_rdata   <= (!pready || r_pwrite || pslverr) ? '0 : prdata;
          end
        end

        default: begin // S_RESP: hold the response until it is consumed
          if (rsp_ready) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_pwrite      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator. The bench plays the APB completer;
// expected outcomes are derived from the wait-state count of each transfer.
`timescale 1ns/1ps
module tb_apb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // One complete transfer. Entered and left at a falling edge.
  // waits = ACCESS cycles with pready low before the completer answers.
  task automatic run_xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input int waits, input logic slverr, input logic [DW-1:0] rd,
                          input int stall, input logic hold_next, output int acc_wait);
    logic          exp_to;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [SW-1:0] exp_strb;
    int            n_access;
    exp_to    = (TO != 0) && (waits >= TO);
    n_access  = exp_to ? TO : waits + 1;
    exp_err   = exp_to | slverr;
    exp_rdata = (exp_to || wr || slverr) ? '0 : rd;
    exp_strb  = wr ? strb : '0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    acc_wait = 0;
    while (cmd_ready !== 1'b1 && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=%b after %0d cycles, required 1", name, cmd_ready, acc_wait);
      cmd_valid = 1'b0;
      return;
    end

    // SETUP: scramble the command inputs and offer a bogus pready; both must be ignored.
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = SW'($urandom);
    pready = 1'b1; pslverr = 1'($urandom); prdata = $urandom;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL %s setup: psel,penable,cmd_ready,rsp_valid=%b required 1000", name,
               {psel, penable, cmd_ready, rsp_valid});
    end
    @(negedge clk);

    for (int i = 1; i <= n_access; i++) begin
      checks++;
      if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1100 || pwrite !== wr || paddr !== addr ||
          pstrb !== exp_strb || (wr && pwdata !== wdata)) begin
        errors++;
        $display("FAIL %s access%0d: ctl=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h required ctl=1100 pwrite=%b paddr=%h pwdata=%h pstrb=%h",
                 name, i, {psel, penable, rsp_valid, cmd_ready}, pwrite, paddr, pwdata, pstrb,
                 wr, addr, wdata, exp_strb);
      end
      pready  = !exp_to && (i == waits + 1);
      pslverr = pready ? slverr : 1'($urandom);
      prdata  = pready ? rd : $urandom;
      @(negedge clk);
    end
    // Completer status outside ACCESS is junk the initiator must ignore.
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    if (hold_next) begin
      cmd_valid = 1'b1; cmd_addr = $urandom;
    end

    for (int i = 0; i <= stall; i++) begin
      checks++;
      if ({rsp_valid, psel, penable, cmd_ready} !== 4'b1000 || rsp_err !== exp_err ||
          rsp_timeout !== exp_to || rsp_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL %s resp%0d: ctl=%b err=%b to=%b rdata=%h required ctl=1000 err=%b to=%b rdata=%h",
                 name, i, {rsp_valid, psel, penable, cmd_ready}, rsp_err, rsp_timeout, rsp_rdata,
                 exp_err, exp_to, exp_rdata);
      end
      if (i == stall) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL %s consume: rsp_valid,rsp_err,rsp_timeout,cmd_ready=%b required 0001", name,
               {rsp_valid, rsp_err, rsp_timeout, cmd_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite} !== 7'b0 ||
        paddr !== '0 || pwdata !== '0 || pstrb !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b paddr=%h pwdata=%h pstrb=%h rdata=%h required all 0",
               {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite},
               paddr, pwdata, pstrb, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, psel, penable} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle: cmd_ready,rsp_valid,psel,penable=%b required 1000",
               {cmd_ready, rsp_valid, psel, penable});
    end
  endtask

  task automatic test_read_zero_wait();
    int w;
    run_xfer("read0", 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, 32'hDEADBEEF, 0, 1'b0, w);
  endtask

  task automatic test_write_waits();
    int w;
    run_xfer("write3", 1'b1, 32'h20, 32'h12345678, 4'hF, 3, 1'b0, 32'hCAFEF00D, 0, 1'b0, w);
  endtask

  task automatic test_pslverr();
    int w;
    run_xfer("slverr", 1'b0, 32'h30, 32'h0, 4'h0, 1, 1'b1, 32'hFFFF0000, 1, 1'b0, w);
  endtask

  task automatic test_timeout();
    int w;
    run_xfer("timeout", 1'b0, 32'h44, 32'h0, 4'h0, TO + 6, 1'b0, 32'h5555AAAA, 0, 1'b0, w);
    run_xfer("to_edge", 1'b0, 32'h48, 32'h0, 4'h0, TO - 1, 1'b0, 32'h600DF00D, 0, 1'b0, w);
  endtask

  task automatic test_backpressure();
    int w;
    run_xfer("bp_first", 1'b1, 32'h50, 32'hA5A5A5A5, 4'h3, 0, 1'b0, 32'h0, 5, 1'b1, w);
    run_xfer("bp_second", 1'b0, 32'h54, 32'h0, 4'h0, 0, 1'b0, 32'h13572468, 0, 1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL bp_next_accept: waited %0d cycles, required 0", w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    run_xfer("b2b_a", 1'b0, 32'h60, 32'h0, 4'h0, 0, 1'b0, 32'h11112222, 0, 1'b0, w);
    run_xfer("b2b_b", 1'b1, 32'h64, 32'h33334444, 4'hC, 0, 1'b0, 32'h0, 0, 1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL b2b_spacing: waited %0d cycles, required 0", w);
    end
  endtask

  task automatic test_reset_mid_access();
    int w;
    int guard;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h70;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cmd_valid = 1'b0; pready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre: psel,penable=%b required 11", {psel, penable});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready, rsp_err} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_async: psel,penable,rsp_valid,cmd_ready,rsp_err=%b required 00000",
               {psel, penable, rsp_valid, cmd_ready, rsp_err});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, psel} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_abandon: rsp_valid,psel=%b required 00", {rsp_valid, psel});
      end
    end
    run_xfer("post_rst", 1'b0, 32'h74, 32'h0, 4'h0, 2, 1'b0, 32'h0BADC0DE, 0, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 30; n++) begin
      run_xfer("rand", 1'($urandom), $urandom, $urandom, SW'($urandom),
               int'($urandom_range(0, TO + 1)), 1'($urandom), $urandom,
               int'($urandom_range(0, 3)), 1'b0, w);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_pslverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
